// File: rtl/rename_commit_ctrl.sv
// In-order commit queue between an allocator and a rename file: it hands out slot tags,
// tracks writeback completion and releases each slot's name in allocation order.
module rename_commit_ctrl #(
  parameter int name_width = 1,
  parameter int tag_width  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ALLOC_REQ,
  input  logic                  RF_ALLOC_READY,
  input  logic [name_width-1:0] RF_NAME,
  output logic                  ALLOC_E,
  output logic [tag_width-1:0]  ALLOC_TAG,
  input  logic                  WB_E,
  input  logic [tag_width-1:0]  WB_TAG,
  input  logic                  COMMIT_STALL,
  output logic                  FE,
  output logic [name_width-1:0] NAME_F,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [tag_width:0]    COUNT
);

  localparam int depth = 2 ** tag_width;
  localparam logic [tag_width:0] depth_cnt = (tag_width + 1)'(depth);

  logic [depth-1:0]      valid;
  logic [depth-1:0]      done;
  logic [name_width-1:0] names [depth];
  logic [tag_width-1:0]  head;
  logic [tag_width-1:0]  tail;
  logic [tag_width:0]    count;
  logic                  wb_hit;

  // FULL comes from the registered count, so a same-cycle commit never unblocks allocation.
  assign FULL      = (count == depth_cnt);
  assign EMPTY     = (count == '0);
  assign COUNT     = count;
  assign ALLOC_E   = ALLOC_REQ & RF_ALLOC_READY & ~FULL;
  assign ALLOC_TAG = tail;
  assign FE        = valid[head] & done[head] & ~COMMIT_STALL;
  assign NAME_F    = names[head];

  // A writeback aimed at the slot retiring on this edge is dropped; the clear wins.
  assign wb_hit = WB_E & valid[WB_TAG] & ~(FE & (WB_TAG == head));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (FE) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      if (wb_hit) begin
        done[WB_TAG] <= 1'b1;
      end
      // Tail is never the retiring head here: tail==head only when empty, and then FE=0.
      if (ALLOC_E) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + 1'b1;
      end
      if (ALLOC_E && !FE) begin
        count <= count + 1'b1;
      end else if (FE && !ALLOC_E) begin
        count <= count - 1'b1;
      end
    end
  end

  // Names are qualified by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    if (ALLOC_E) begin
      names[tail] <= RF_NAME;
    end
  end

endmodule
